// File: rtl/mem_entry_controller_pkg.sv
// Shared types for the key/switch memory entry sequencer.
// State encoding, mode codes, chunk-count helper.
package mem_entry_controller_pkg;

  typedef enum logic [7:0] {
    S_IDLE  = 8'h01,
    S_SEL_R = 8'h02,
    S_SEL_W = 8'h04,
    S_ADDR  = 8'h08,
    S_DATA  = 8'h10,
    S_WAIT  = 8'h20,
    S_DONE  = 8'h40,
    S_ERR   = 8'h80
  } state_t;

  localparam logic [1:0] MODE_IDLE  = 2'b00;
  localparam logic [1:0] MODE_READ  = 2'b01;
  localparam logic [1:0] MODE_WRITE = 2'b10;
  localparam logic [1:0] MODE_ERR   = 2'b11;

  localparam int IDX_W = 8;

  function automatic int chunk_count(input int w, input int c);
    int n;
    n = w / c;
    return (n < 1) ? 1 : n;
  endfunction

endpackage

// File: rtl/mem_entry_controller_chunk_assembler.sv
// Builds a W-bit field from successive switch chunks.
// Ports: load/idx write one chunk, clear zeroes, inc adds one.
module chunk_assembler
  import mem_entry_controller_pkg::*;
#(
  parameter int W       = 16,
  parameter int CHUNK_W = 8,
  parameter int SW_W    = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic             inc,
  input  logic [IDX_W-1:0] idx,
  input  logic [SW_W-1:0]  sw,
  output logic [W-1:0]     value
);

  localparam int N    = chunk_count(W, CHUNK_W);
  localparam int LAST = W - (N - 1) * CHUNK_W;

  if (SW_W < LAST) begin : g_sw_too_narrow
    $error("switch bank narrower than final chunk");
  end

  logic [W-1:0] nxt;
  logic         unused_sw;

  // Upper switch bits beyond the widest chunk are don't-care.
  assign unused_sw = ^sw;

  always_comb begin
    nxt = value;
    if (clear) begin
      nxt = '0;
    end else if (inc) begin
      nxt = value + W'(1);
    end else if (load) begin
      if (idx == IDX_W'(N - 1)) begin
        // Final chunk absorbs the remainder bits.
        nxt[W-1 -: LAST] = sw[LAST-1:0];
      end else begin
        for (int k = 0; k < N - 1; k++) begin
          if (idx == IDX_W'(k)) begin
            nxt[k*CHUNK_W +: CHUNK_W] = sw[CHUNK_W-1:0];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value <= '0;
    end else begin
      value <= nxt;
    end
  end

endmodule

// File: rtl/mem_entry_controller.sv
// Key/switch driven memory access sequencer with abort, timeout, repeat.
// In: keys, sw, mem_done, read_data. Out: mode, address, data, io_req, error, state.
module mem_entry_controller
  import mem_entry_controller_pkg::*;
#(
  parameter int ADDR_W  = 25,
  parameter int DATA_W  = 16,
  parameter int CHUNK_W = 8,
  parameter int SW_W    = 9,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key0_pulse,
  input  logic              key1_pulse,
  input  logic [SW_W-1:0]   sw,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] read_data,
  output logic [1:0]        mode_out,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] display_data,
  output logic              io_req,
  output logic              error,
  output logic [7:0]        state_out
);

  localparam int N_A = chunk_count(ADDR_W, CHUNK_W);
  localparam int N_D = chunk_count(DATA_W, CHUNK_W);
  localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [IDX_W-1:0] A_LAST = IDX_W'(N_A - 1);
  localparam logic [IDX_W-1:0] D_LAST = IDX_W'(N_D - 1);

  state_t           state, state_nxt;
  logic             wr_op, wr_nxt;
  logic [IDX_W-1:0] idx, idx_nxt, ld_idx;
  logic [TW-1:0]    tcnt;
  logic             a_load, a_clear, a_inc;
  logic             d_load, d_clear;
  logic             disp_load;
  logic             timeout_hit;

  assign timeout_hit = (TIMEOUT != 0) &&
                       (tcnt == TW'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    wr_nxt    = wr_op;
    idx_nxt   = idx;
    ld_idx    = idx;
    a_load    = 1'b0;
    a_inc     = 1'b0;
    d_load    = 1'b0;
    disp_load = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (key0_pulse) state_nxt = S_SEL_R;
      end
      S_SEL_R, S_SEL_W: begin
        if (key0_pulse) begin
          state_nxt = (state == S_SEL_R) ? S_SEL_W : S_SEL_R;
        end else if (key1_pulse) begin
          a_load  = 1'b1;
          ld_idx  = '0;
          wr_nxt  = (state == S_SEL_W);
          idx_nxt = IDX_W'(1);
          if (N_A == 1) begin
            idx_nxt   = '0;
            state_nxt = (state == S_SEL_W) ? S_DATA : S_WAIT;
          end else begin
            state_nxt = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (key0_pulse) begin
          state_nxt = S_IDLE;
        end else if (key1_pulse) begin
          a_load = 1'b1;
          if (idx == A_LAST) begin
            idx_nxt   = '0;
            state_nxt = wr_op ? S_DATA : S_WAIT;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end
      S_DATA: begin
        if (key0_pulse) begin
          state_nxt = S_IDLE;
        end else if (key1_pulse) begin
          d_load = 1'b1;
          if (idx == D_LAST) begin
            state_nxt = S_WAIT;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end
      S_WAIT: begin
        // Completion beats a coincident timeout.
        if (mem_done) begin
          state_nxt = S_DONE;
          disp_load = !wr_op;
        end else if (timeout_hit) begin
          state_nxt = S_ERR;
        end
      end
      S_DONE: begin
        if (key0_pulse) begin
          state_nxt = S_IDLE;
        end else if (key1_pulse) begin
          a_inc     = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_ERR: begin
        if (key0_pulse) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign a_clear = (state_nxt == S_IDLE);
  assign d_clear = (state_nxt == S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      wr_op        <= 1'b0;
      idx          <= '0;
      tcnt         <= '0;
      display_data <= '0;
    end else begin
      state <= state_nxt;
      wr_op <= wr_nxt;
      idx   <= idx_nxt;
      tcnt  <= (state == S_WAIT) ? tcnt + TW'(1) : '0;
      if (disp_load) display_data <= read_data;
    end
  end

  chunk_assembler #(
    .W       (ADDR_W),
    .CHUNK_W (CHUNK_W),
    .SW_W    (SW_W)
  ) u_addr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (a_load),
    .clear (a_clear),
    .inc   (a_inc),
    .idx   (ld_idx),
    .sw    (sw),
    .value (mem_address)
  );

  chunk_assembler #(
    .W       (DATA_W),
    .CHUNK_W (CHUNK_W),
    .SW_W    (SW_W)
  ) u_data (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (d_load),
    .clear (d_clear),
    .inc   (1'b0),
    .idx   (idx),
    .sw    (sw),
    .value (write_data)
  );

  always_comb begin
    mode_out = MODE_IDLE;
    unique case (state)
      S_SEL_R:                mode_out = MODE_READ;
      S_SEL_W, S_DATA:        mode_out = MODE_WRITE;
      S_ADDR, S_WAIT, S_DONE: mode_out = wr_op ? MODE_WRITE : MODE_READ;
      S_ERR:                  mode_out = MODE_ERR;
      default:                mode_out = MODE_IDLE;
    endcase
  end

  assign io_req    = (state == S_WAIT);
  assign error     = (state == S_ERR);
  assign state_out = state;

endmodule

// File: tb/tb_mem_entry_controller.sv
// Scoreboard bench for mem_entry_controller.
// Two instances: default widths with short timeout, and 8/32-bit widths.
module tb_mem_entry_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  k0, k1, dn;
  logic [8:0]  sw;
  logic [15:0] rd0;
  logic [31:0] rd1;

  logic [1:0]  mode0, mode1;
  logic [24:0] addr0;
  logic [7:0]  addr1;
  logic [15:0] wd0, disp0;
  logic [31:0] wd1, disp1;
  logic        io0, io1, err0, err1;
  logic [7:0]  st0, st1;

  always #5 clk = ~clk;

  mem_entry_controller #(
    .ADDR_W(25), .DATA_W(16), .CHUNK_W(8), .SW_W(9), .TIMEOUT(4)
  ) u0 (
    .clk(clk), .rst_n(rst_n),
    .key0_pulse(k0[0]), .key1_pulse(k1[0]),
    .sw(sw), .mem_done(dn[0]), .read_data(rd0),
    .mode_out(mode0), .mem_address(addr0),
    .write_data(wd0), .display_data(disp0),
    .io_req(io0), .error(err0), .state_out(st0)
  );

  mem_entry_controller #(
    .ADDR_W(8), .DATA_W(32), .CHUNK_W(8), .SW_W(9), .TIMEOUT(0)
  ) u1 (
    .clk(clk), .rst_n(rst_n),
    .key0_pulse(k0[1]), .key1_pulse(k1[1]),
    .sw(sw), .mem_done(dn[1]), .read_data(rd1),
    .mode_out(mode1), .mem_address(addr1),
    .write_data(wd1), .display_data(disp1),
    .io_req(io1), .error(err1), .state_out(st1)
  );

  typedef struct {
    string       nm;
    bit          b;
    logic [1:0]  mode;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] disp;
    logic        io;
    logic        err;
    logic [7:0]  st;
  } snap_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wd;
    logic [1:0]  mode;
  } req_t;

  snap_t snap_q[$];
  req_t  req_q0[$];
  req_t  req_q1[$];
  int    n_vec = 0;
  int    n_err = 0;
  bit    sel = 1'b0;

  task automatic tick(input bit a, input bit b, input logic [8:0] s,
                      input bit d);
    sw = s;
    k0[sel] = a;
    k1[sel] = b;
    dn[sel] = d;
    @(posedge clk);
    #1;
    k0 = '0;
    k1 = '0;
    dn = '0;
  endtask

  task automatic key0();
    tick(1'b1, 1'b0, 9'h0, 1'b0);
  endtask

  task automatic key1(input logic [8:0] s);
    tick(1'b0, 1'b1, s, 1'b0);
  endtask

  task automatic both(input logic [8:0] s);
    tick(1'b1, 1'b1, s, 1'b0);
  endtask

  task automatic done();
    tick(1'b0, 1'b0, 9'h0, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, 9'h0, 1'b0);
  endtask

  task automatic chk(input string nm, input logic [1:0] m,
                     input logic [31:0] a, input logic [31:0] w,
                     input logic [31:0] d, input logic io,
                     input logic er, input logic [7:0] s);
    snap_t e;
    e.nm = nm; e.b = sel; e.mode = m; e.addr = a; e.wd = w;
    e.disp = d; e.io = io; e.err = er; e.st = s;
    snap_q.push_back(e);
  endtask

  task automatic req(input logic [31:0] a, input logic [31:0] w,
                     input logic [1:0] m);
    req_t r;
    r.addr = a; r.wd = w; r.mode = m;
    if (sel) req_q1.push_back(r);
    else     req_q0.push_back(r);
  endtask

  // Monitor: state snapshots plus every rising io_req.
  logic  p0, p1;
  snap_t se;
  req_t  re;
  logic [1:0]  am;
  logic [31:0] aa, aw, ad;
  logic        ai, ae;
  logic [7:0]  as;

  initial begin
    p0 = 1'b0;
    p1 = 1'b0;
    forever begin
      @(negedge clk);
      while (snap_q.size() > 0) begin
        se = snap_q.pop_front();
        am = se.b ? mode1 : mode0;
        aa = se.b ? {24'h0, addr1} : {7'h0, addr0};
        aw = se.b ? wd1 : {16'h0, wd0};
        ad = se.b ? disp1 : {16'h0, disp0};
        ai = se.b ? io1 : io0;
        ae = se.b ? err1 : err0;
        as = se.b ? st1 : st0;
        n_vec++;
        if ({am, aa, aw, ad, ai, ae, as} !==
            {se.mode, se.addr, se.wd, se.disp, se.io, se.err, se.st}) begin
          n_err++;
          $display("FAIL %s: got mode=%h addr=%h wd=%h disp=%h io=%b err=%b st=%h want mode=%h addr=%h wd=%h disp=%h io=%b err=%b st=%h",
                   se.nm, am, aa, aw, ad, ai, ae, as,
                   se.mode, se.addr, se.wd, se.disp, se.io, se.err, se.st);
        end
      end
      if (io0 === 1'b1 && p0 === 1'b0) begin
        n_vec++;
        if (req_q0.size() == 0) begin
          n_err++;
          $display("FAIL req0: unexpected request addr=%h", addr0);
        end else begin
          re = req_q0.pop_front();
          if ({7'h0, addr0} !== re.addr || {16'h0, wd0} !== re.wd ||
              mode0 !== re.mode) begin
            n_err++;
            $display("FAIL req0: got addr=%h wd=%h mode=%h want addr=%h wd=%h mode=%h",
                     addr0, wd0, mode0, re.addr, re.wd, re.mode);
          end
        end
      end
      if (io1 === 1'b1 && p1 === 1'b0) begin
        n_vec++;
        if (req_q1.size() == 0) begin
          n_err++;
          $display("FAIL req1: unexpected request addr=%h", addr1);
        end else begin
          re = req_q1.pop_front();
          if ({24'h0, addr1} !== re.addr || wd1 !== re.wd ||
              mode1 !== re.mode) begin
            n_err++;
            $display("FAIL req1: got addr=%h wd=%h mode=%h want addr=%h wd=%h mode=%h",
                     addr1, wd1, mode1, re.addr, re.wd, re.mode);
          end
        end
      end
      p0 = io0;
      p1 = io1;
    end
  end

  initial begin
    rst_n = 1'b0;
    k0 = '0; k1 = '0; dn = '0;
    sw = '0; rd0 = '0; rd1 = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Default-width instance
    sel = 1'b0;
    chk("reset", 2'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 8'h01);

    key0();
    chk("sel_r", 2'd1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 8'h02);
    req(32'h1AB3412, 32'h0, 2'd1);
    key1(9'h012);
    chk("rd_a0", 2'd1, 32'h12, 32'h0, 32'h0, 1'b0, 1'b0, 8'h08);
    key1(9'h034);
    key1(9'h1AB);
    chk("rd_wait", 2'd1, 32'h1AB3412, 32'h0, 32'h0, 1'b1, 1'b0, 8'h20);
    rd0 = 16'hBEEF;
    done();
    chk("rd_done", 2'd1, 32'h1AB3412, 32'h0, 32'hBEEF, 1'b0, 1'b0, 8'h40);
    key0();
    chk("rd_idle", 2'd0, 32'h0, 32'h0, 32'hBEEF, 1'b0, 1'b0, 8'h01);

    key0();
    key0();
    chk("sel_w", 2'd2, 32'h0, 32'h0, 32'hBEEF, 1'b0, 1'b0, 8'h04);
    req(32'h1, 32'hABCD, 2'd2);
    key1(9'h001);
    key1(9'h000);
    key1(9'h000);
    chk("wr_data", 2'd2, 32'h1, 32'h0, 32'hBEEF, 1'b0, 1'b0, 8'h10);
    key1(9'h0CD);
    key1(9'h0AB);
    chk("wr_wait", 2'd2, 32'h1, 32'hABCD, 32'hBEEF, 1'b1, 1'b0, 8'h20);
    idle(1);
    chk("wr_hold", 2'd2, 32'h1, 32'hABCD, 32'hBEEF, 1'b1, 1'b0, 8'h20);
    done();
    chk("wr_done", 2'd2, 32'h1, 32'hABCD, 32'hBEEF, 1'b0, 1'b0, 8'h40);

    req(32'h2, 32'hABCD, 2'd2);
    key1(9'h000);
    chk("rep_wait", 2'd2, 32'h2, 32'hABCD, 32'hBEEF, 1'b1, 1'b0, 8'h20);
    done();
    chk("rep_done", 2'd2, 32'h2, 32'hABCD, 32'hBEEF, 1'b0, 1'b0, 8'h40);

    key0();
    key0();
    req(32'h1FFFFFF, 32'h0, 2'd1);
    key1(9'h0FF);
    key1(9'h0FF);
    key1(9'h1FF);
    rd0 = 16'h1234;
    done();
    chk("wrap_pre", 2'd1, 32'h1FFFFFF, 32'h0, 32'h1234, 1'b0, 1'b0, 8'h40);
    req(32'h0, 32'h0, 2'd1);
    key1(9'h000);
    chk("wrap_wait", 2'd1, 32'h0, 32'h0, 32'h1234, 1'b1, 1'b0, 8'h20);
    rd0 = 16'h5678;
    done();
    chk("wrap_done", 2'd1, 32'h0, 32'h0, 32'h5678, 1'b0, 1'b0, 8'h40);

    key0();
    key0();
    req(32'h70605, 32'h0, 2'd1);
    key1(9'h005);
    key1(9'h006);
    key1(9'h007);
    key0();
    chk("wait_key0", 2'd1, 32'h70605, 32'h0, 32'h5678, 1'b1, 1'b0, 8'h20);
    idle(2);
    chk("to_pre", 2'd1, 32'h70605, 32'h0, 32'h5678, 1'b1, 1'b0, 8'h20);
    idle(1);
    chk("to_err", 2'd3, 32'h70605, 32'h0, 32'h5678, 1'b0, 1'b1, 8'h80);
    key0();
    chk("err_clr", 2'd0, 32'h0, 32'h0, 32'h5678, 1'b0, 1'b0, 8'h01);

    key0();
    req(32'h1, 32'h0, 2'd1);
    key1(9'h001);
    key1(9'h000);
    key1(9'h000);
    idle(3);
    rd0 = 16'hCAFE;
    done();
    chk("tie_done", 2'd1, 32'h1, 32'h0, 32'hCAFE, 1'b0, 1'b0, 8'h40);

    key0();
    key0();
    key1(9'h055);
    chk("ab_addr", 2'd1, 32'h55, 32'h0, 32'hCAFE, 1'b0, 1'b0, 8'h08);
    key0();
    chk("ab_idle", 2'd0, 32'h0, 32'h0, 32'hCAFE, 1'b0, 1'b0, 8'h01);
    key0();
    both(9'h077);
    chk("prio", 2'd2, 32'h0, 32'h0, 32'hCAFE, 1'b0, 1'b0, 8'h04);

    req(32'h3, 32'h2211, 2'd2);
    key1(9'h003);
    key1(9'h000);
    key1(9'h000);
    key1(9'h011);
    key1(9'h022);
    chk("rs_wait", 2'd2, 32'h3, 32'h2211, 32'hCAFE, 1'b1, 1'b0, 8'h20);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rs_mid", 2'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 8'h01);

    // 8-bit address / 32-bit data instance
    sel = 1'b1;
    chk("b_reset", 2'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 8'h01);
    key0();
    key0();
    req(32'hA5, 32'h44332211, 2'd2);
    key1(9'h0A5);
    chk("b_data", 2'd2, 32'hA5, 32'h0, 32'h0, 1'b0, 1'b0, 8'h10);
    key1(9'h011);
    key1(9'h022);
    key1(9'h033);
    key1(9'h044);
    chk("b_wait", 2'd2, 32'hA5, 32'h44332211, 32'h0, 1'b1, 1'b0, 8'h20);
    idle(8);
    chk("b_noto", 2'd2, 32'hA5, 32'h44332211, 32'h0, 1'b1, 1'b0, 8'h20);
    done();
    chk("b_done", 2'd2, 32'hA5, 32'h44332211, 32'h0, 1'b0, 1'b0, 8'h40);
    key0();
    key0();
    req(32'hFF, 32'h0, 2'd1);
    key1(9'h0FF);
    chk("b_rd_wait", 2'd1, 32'hFF, 32'h0, 32'h0, 1'b1, 1'b0, 8'h20);
    rd1 = 32'hDEADBEEF;
    done();
    chk("b_rd_done", 2'd1, 32'hFF, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 8'h40);
    req(32'h0, 32'h0, 2'd1);
    key1(9'h000);
    chk("b_wrap", 2'd1, 32'h0, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 8'h20);
    done();
    idle(2);

    while (req_q0.size() > 0) begin
      re = req_q0.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL req0_missing: got none want addr=%h", re.addr);
    end
    while (req_q1.size() > 0) begin
      re = req_q1.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL req1_missing: got none want addr=%h", re.addr);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
